// File: rtl/huffman_bit_packer.sv
// Packs variable-length codewords MSB-first into bytes, with flush and zero padding.
// Optional saturating byte counter on out_count when HUFF_PACK_STATS_EN is defined.
module huffman_bit_packer #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned ACC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_code,
    input  logic [3:0]         in_len,
    input  logic               in_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last
`ifdef HUFF_PACK_STATS_EN
    ,
    output logic [15:0]        out_count
`endif
);

    localparam int unsigned FW = $clog2(ACC_W + 1);

    typedef enum logic {StRun, StDrain} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_pop, code_al;
    logic [FW-1:0]      fill_q, fill_d, fill_pop;
    logic [3:0]         len_c;
    logic [MAX_LEN-1:0] code_m;
    logic               push, pop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            acc_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs decode registered state only
    always_comb begin
        in_ready  = (state_q == StRun) && (fill_q <= FW'(ACC_W - MAX_LEN));
        out_valid = (fill_q >= FW'(8)) || ((state_q == StDrain) && (fill_q != '0));
        out_last  = (state_q == StDrain) && out_valid && (fill_q <= FW'(8));
        out_byte  = acc_q[ACC_W-1 -: 8];
    end

    // Datapath: the pop shift happens first so a same-cycle push lands behind it
    always_comb begin
        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        len_c = (in_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : in_len;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            code_m[i] = in_code[i] && (i < int'(len_c));
        end
        acc_pop  = pop ? (acc_q << 8) : acc_q;
        fill_pop = fill_q;
        if (pop) begin
            fill_pop = (fill_q >= FW'(8)) ? (fill_q - FW'(8)) : '0;
        end
        code_al = (ACC_W'(code_m) << (ACC_W - 32'(len_c))) >> fill_pop;
        acc_d   = push ? (acc_pop | code_al) : acc_pop;
        fill_d  = push ? (fill_pop + FW'(len_c)) : fill_pop;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (push && in_flush && (fill_d != '0)) state_d = StDrain;
            StDrain: if (pop && out_last) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

`ifdef HUFF_PACK_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed self-checking bench for huffman_bit_packer.
module tb_huffman_bit_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_code = '0;
    logic [3:0] in_len = '0;
    logic       in_flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_byte;
    logic       out_last;
`ifdef HUFF_PACK_STATS_EN
    logic [15:0] out_count;
`endif

    int checks = 0;
    int fails  = 0;

    huffman_bit_packer #(.MAX_LEN(8), .ACC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_len    (in_len),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
`ifdef HUFF_PACK_STATS_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, let it be accepted at the next edge
    task automatic beat(input logic [7:0] c, input logic [3:0] l, input logic f);
        int n = 0;
        in_valid = 1'b1; in_code = c; in_len = l; in_flush = f;
        while (!in_ready && n < 20) begin step(); n++; end
        checks++;
        if (!in_ready) begin $display("FAIL beat_timeout: in_ready=%b required 1", in_ready); fails++; end
        step();
        in_valid = 1'b0; in_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0; step();
        out_ready = 1'b0;
        beat(8'hFF, 4'd8, 1'b0);
        checks++; if (out_valid !== 1'b1) begin $display("FAIL rst_pre_valid: got %b want 1", out_valid); fails++; end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); fails++; end
        checks++; if (out_byte !== 8'h00) begin $display("FAIL rst_byte: got %h want 00", out_byte); fails++; end
        checks++; if (out_last !== 1'b0) begin $display("FAIL rst_last: got %b want 0", out_last); fails++; end
        checks++; if (in_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", in_ready); fails++; end
`ifdef HUFF_PACK_STATS_EN
        checks++; if (out_count !== 16'd0) begin $display("FAIL rst_count: got %0d want 0", out_count); fails++; end
`endif
        step(); step();
        rst = 1'b0; step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_post_valid: got %b want 0", out_valid); fails++; end
    endtask

    task automatic test_packing();
        out_ready = 1'b1;
        beat(8'h05, 4'd3, 1'b0);
        checks++; if (out_valid !== 1'b0) begin $display("FAIL pack_partial: got %b want 0", out_valid); fails++; end
        beat(8'h19, 4'd5, 1'b0);
        checks++; if (out_byte !== 8'hB9 || out_valid !== 1'b1) begin
            $display("FAIL pack_byte: got %h/%b want B9/1", out_byte, out_valid); fails++; end
        checks++; if (out_last !== 1'b0) begin $display("FAIL pack_last: got %b want 0", out_last); fails++; end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL pack_empty: got valid=%b ready=%b want 0/1", out_valid, in_ready); fails++; end
`ifdef HUFF_PACK_STATS_EN
        checks++; if (out_count !== 16'd1) begin $display("FAIL pack_count: got %0d want 1", out_count); fails++; end
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        beat(8'h0F, 4'd4, 1'b1);
        checks++; if (in_ready !== 1'b0) begin $display("FAIL flush_ready: got %b want 0", in_ready); fails++; end
        checks++; if (out_byte !== 8'hF0 || out_last !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL flush_byte: got %h last=%b valid=%b want F0/1/1", out_byte, out_last, out_valid); fails++; end
        out_ready = 1'b1; step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL flush_back_run: got ready=%b valid=%b want 1/0", in_ready, out_valid); fails++; end
        beat(8'h00, 4'd0, 1'b1);
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_empty: got valid=%b last=%b ready=%b want 0/0/1", out_valid, out_last, in_ready); fails++; end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(8'hAA, 4'd8, 1'b0);
        beat(8'h55, 4'd8, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_byte !== 8'hAA) begin
            $display("FAIL bp_full: got ready=%b byte=%h want 0/AA", in_ready, out_byte); fails++; end
        in_valid = 1'b1; in_code = 8'h3C; in_len = 4'd8;
        step(); step();
        checks++; if (out_byte !== 8'hAA || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL bp_hold: got byte=%h ready=%b valid=%b want AA/0/1", out_byte, in_ready, out_valid); fails++; end
        out_ready = 1'b1; step();
        checks++; if (out_byte !== 8'h55 || in_ready !== 1'b1) begin
            $display("FAIL bp_second: got byte=%h ready=%b want 55/1", out_byte, in_ready); fails++; end
        step();
        in_valid = 1'b0;
        checks++; if (out_byte !== 8'h3C || out_valid !== 1'b1) begin
            $display("FAIL bp_third: got byte=%h valid=%b want 3C/1", out_byte, out_valid); fails++; end
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_drained: got %b want 0", out_valid); fails++; end
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        beat(8'hAB, 4'd8, 1'b0);
        beat(8'h0C, 4'd4, 1'b0);
        checks++; if (out_byte !== 8'hAB || in_ready !== 1'b0) begin
            $display("FAIL sim_fill12: got byte=%h ready=%b want AB/0", out_byte, in_ready); fails++; end
        in_valid = 1'b1; in_code = 8'hFF; in_len = 4'd8; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL sim_fill4: got valid=%b ready=%b want 0/1", out_valid, in_ready); fails++; end
        step();
        in_valid = 1'b0;
        checks++; if (out_byte !== 8'hCF || out_valid !== 1'b1) begin
            $display("FAIL sim_cf: got byte=%h valid=%b want CF/1", out_byte, out_valid); fails++; end
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL sim_rem: got %b want 0", out_valid); fails++; end
        beat(8'h00, 4'd0, 1'b1);
        checks++; if (out_byte !== 8'hF0 || out_last !== 1'b1) begin
            $display("FAIL sim_tail: got byte=%h last=%b want F0/1", out_byte, out_last); fails++; end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL sim_done: got valid=%b ready=%b want 0/1", out_valid, in_ready); fails++; end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_code = codes[k]; in_len = 4'd8;
            checks++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); fails++; end
            step();
            checks++; if (out_byte !== codes[k] || out_valid !== 1'b1) begin
                $display("FAIL b2b_byte%0d: got %h/%b want %h/1", k, out_byte, out_valid, codes[k]); fails++; end
        end
        in_valid = 1'b0; step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_end: got %b want 0", out_valid); fails++; end
        out_ready = 1'b0;
    endtask

    task automatic test_clamp_reset_drain();
        out_ready = 1'b0;
        beat(8'hFF, 4'd12, 1'b0);
        checks++; if (out_byte !== 8'hFF || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL clamp: got byte=%h valid=%b ready=%b want FF/1/1", out_byte, out_valid, in_ready); fails++; end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL clamp_pop: got %b want 0", out_valid); fails++; end
        beat(8'hF5, 4'd5, 1'b1);
        checks++; if (out_byte !== 8'hA8 || out_last !== 1'b1) begin
            $display("FAIL drain5: got byte=%h last=%b want A8/1", out_byte, out_last); fails++; end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL drain_rst: got valid=%b byte=%h last=%b ready=%b want 0/00/0/1",
                     out_valid, out_byte, out_last, in_ready); fails++; end
        out_ready = 1'b1;
        step(); step();
        rst = 1'b0; step();
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            $display("FAIL drain_after: got valid=%b last=%b want 0/0", out_valid, out_last); fails++; end
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_packing();
        test_flush();
        test_backpressure();
        test_simultaneous();
        test_back_to_back();
        test_clamp_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
